dmem_param: RTL and testbench

Parametrised data memory for the single-cycle CPU data path, successor to the fixed 32-bit `dmemory32`. It adds configurable width and depth, byte, halfword and word stores and loads with sign or zero extension, and a registered read with a valid strobe. It also has a UART program-load (UPG) port that takes the memory away from the CPU for bulk initialisation. It sits between the CPU memory-stage controls and the UART loader.

---
 rtl/dmem_param_if.sv | 34 +++
 rtl/dmem_param.sv | 131 +++++++++++++
 tb/tb_dmem_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_param_if.sv
// CPU memory-stage and UART program-load (UPG) bus for dmem_param.
// master = CPU/loader side, slave = the memory.
interface dmem_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 14
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       addr;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              misalign;
  logic              upg_start;
  logic              upg_wen;
  logic [AW-1:0]     upg_adr;
  logic [DATA_W-1:0] upg_dat;
  logic              upg_done;
  logic              busy;

  modport master (
    output mem_read, mem_write, addr, size, unsigned_ld, write_data,
    output upg_start, upg_wen, upg_adr, upg_dat, upg_done,
    input  read_data, read_valid, misalign, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, size, unsigned_ld, write_data,
    input  upg_start, upg_wen, upg_adr, upg_dat, upg_done,
    output read_data, read_valid, misalign, busy
  );
endinterface

// File: rtl/dmem_param.sv
// Parametrised data memory: byte/half/word stores, extended registered loads, UART program-load mode.
// Optional DMEM_MISALIGN_TRAP_EN: flag and suppress misaligned half/word accesses.
module dmem_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input logic         clock,
  input logic         reset,
  dmem_param_if.slave bus
);
  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic {ST_CPU, ST_UPG} stateE;

  stateE             state;
  logic              busyQ;
  logic              readValidQ;
  logic              misalignQ;
  logic [DATA_W-1:0] readDataQ;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wordIdx;
  logic [1:0]        byteOff;
  logic              outOfRange;
  logic              misAl;
  logic              cpuActive;
  logic              doStore;
  logic              doLoad;
  logic              upgWe;
  logic [NB-1:0]     laneEn;
  logic [DATA_W-1:0] storeWord;
  logic [DATA_W-1:0] rdWord;
  logic [7:0]        ldByte;
  logic [15:0]       ldHalf;
  logic [DATA_W-1:0] loadExt;

  assign wordIdx    = bus.addr[AW+1:2];
  assign byteOff    = bus.addr[1:0];
  assign outOfRange = |(bus.addr >> (AW + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misAl = ((bus.size == 2'b01) && byteOff[0]) || (bus.size[1] && (byteOff != 2'b00));
`else
  assign misAl = 1'b0;
`endif

  assign cpuActive = (state == ST_CPU);
  assign doStore   = cpuActive && bus.mem_write && !outOfRange && !misAl && !reset;
  assign doLoad    = cpuActive && bus.mem_read && !bus.mem_write;
  assign upgWe     = (state == ST_UPG) && bus.upg_wen && !reset;

  // Lane enables and store data replicated across lanes; the offset bits below the access size are ignored.
  always_comb begin
    laneEn    = '1;
    storeWord = bus.write_data;
    case (bus.size)
      2'b00: begin
        laneEn    = NB'(1) << byteOff;
        storeWord = {NB{bus.write_data[7:0]}};
      end
      2'b01: begin
        laneEn    = NB'(3) << {byteOff[1], 1'b0};
        storeWord = {(NB/2){bus.write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign rdWord = mem[wordIdx];
  assign ldByte = rdWord[{byteOff, 3'b000} +: 8];
  assign ldHalf = rdWord[{byteOff[1], 4'b0000} +: 16];

  always_comb begin
    loadExt = rdWord;
    case (bus.size)
      2'b00:   loadExt = bus.unsigned_ld ? {{(DATA_W-8){1'b0}}, ldByte}
                                         : {{(DATA_W-8){ldByte[7]}}, ldByte};
      2'b01:   loadExt = bus.unsigned_ld ? {{(DATA_W-16){1'b0}}, ldHalf}
                                         : {{(DATA_W-16){ldHalf[15]}}, ldHalf};
      default: ;
    endcase
    if (outOfRange || misAl) loadExt = '0;
  end

  // Array is never reset; writes in the reset cycle are dropped via doStore/upgWe.
  always_ff @(posedge clock) begin
    if (upgWe) begin
      mem[bus.upg_adr] <= bus.upg_dat;
    end else if (doStore) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (laneEn[i]) mem[wordIdx][i*8 +: 8] <= storeWord[i*8 +: 8];
      end
    end
  end

  // Mode FSM plus registered load result and strobes; upg_done has priority over upg_start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_CPU;
      busyQ      <= 1'b0;
      readValidQ <= 1'b0;
      misalignQ  <= 1'b0;
      readDataQ  <= '0;
    end else begin
      readValidQ <= doLoad;
      misalignQ  <= cpuActive && (bus.mem_read || bus.mem_write) && misAl;
      if (doLoad) readDataQ <= loadExt;
      case (state)
        ST_CPU: if (bus.upg_start && !bus.upg_done) begin
          state <= ST_UPG;
          busyQ <= 1'b1;
        end
        ST_UPG: if (bus.upg_done) begin
          state <= ST_CPU;
          busyQ <= 1'b0;
        end
        default: begin
          state <= ST_CPU;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_data  = readDataQ;
  assign bus.read_valid = readValidQ;
  assign bus.misalign   = misalignQ;
  assign bus.busy       = busyQ;
endmodule

// File: tb/tb_dmem_param.sv
// Self-checking bench for dmem_param: directed scenarios plus random traffic against a byte-addressed model.
module tb_dmem_param;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16384;
  localparam int unsigned AW     = 14;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_param_if #(.DATA_W(DATA_W), .AW(AW)) bus ();
  dmem_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          nChecks = 0;
  int          nFails  = 0;
  logic [7:0]  refMem [0:63];
  logic [31:0] expData;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.addr        = '0;
    bus.size        = 2'b10;
    bus.unsigned_ld = 1'b0;
    bus.write_data  = '0;
    bus.upg_start   = 1'b0;
    bus.upg_wen     = 1'b0;
    bus.upg_adr     = '0;
    bus.upg_dat     = '0;
    bus.upg_done    = 1'b0;
  endtask

  function automatic bit isOor(input logic [31:0] a);
    return (a >> (AW + 2)) != 32'd0;
  endfunction

  function automatic bit isMis(input logic [31:0] a, input logic [1:0] sz);
    return TRAP && (((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
  endfunction

  function automatic int accBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Little-endian byte gather from the model, then size extension.
  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input bit uns);
    int          n;
    logic [31:0] base;
    logic [31:0] v;
    if (isOor(a) || isMis(a, sz)) return 32'd0;
    n    = accBytes(sz);
    base = a & ~(32'(n) - 32'd1);
    v    = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(refMem[6'(base + 32'(k))]) << (8 * k));
    if (!uns && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic refStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int          n;
    logic [31:0] base;
    if (isOor(a) || isMis(a, sz)) return;
    n    = accBytes(sz);
    base = a & ~(32'(n) - 32'd1);
    for (int k = 0; k < n; k++) refMem[6'(base + 32'(k))] = wd[8*k +: 8];
  endtask

  task automatic refUpgWrite(input int idx, input logic [31:0] d);
    for (int k = 0; k < 4; k++) refMem[6'(idx * 4 + k)] = d[8*k +: 8];
  endtask

  // One CPU cycle: drive, clock, then compare all CPU-visible outputs with the model.
  task automatic cpuOp(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input bit uns, input logic [31:0] wd, input string tag);
    bit expValid;
    bit expMis;
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.addr        = a;
    bus.size        = sz;
    bus.unsigned_ld = uns;
    bus.write_data  = wd;
    expValid = rd && !wr;
    expMis   = (rd || wr) && isMis(a, sz);
    if (expValid) expData = refLoad(a, sz, uns);
    if (wr) refStore(a, sz, wd);
    @(posedge clock); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    checkVal({tag, "_valid"}, 32'(bus.read_valid), 32'(expValid));
    checkVal({tag, "_data"}, bus.read_data, expData);
    checkVal({tag, "_mis"}, 32'(bus.misalign), 32'(expMis));
    checkVal({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [1:0]  sz;
    bit          rd;
    bit          wr;

    idleInputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkVal("rst_busy", 32'(bus.busy), 32'd0);
    checkVal("rst_valid", 32'(bus.read_valid), 32'd0);
    checkVal("rst_data", bus.read_data, 32'd0);
    checkVal("rst_mis", 32'(bus.misalign), 32'd0);
    reset   = 1'b0;
    expData = 32'd0;

    // Program-load: fill words 0..15 while a CPU store to 0xC is attempted every cycle.
    bus.upg_start = 1'b1;
    @(posedge clock); #1;
    bus.upg_start = 1'b0;
    checkVal("upg_busy_rise", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 15; i++) begin
      d = (i == 3) ? 32'hDEAD_BEEF : $urandom;
      bus.upg_wen    = 1'b1;
      bus.upg_adr    = AW'(i);
      bus.upg_dat    = d;
      bus.mem_write  = 1'b1;
      bus.addr       = 32'hC;
      bus.size       = 2'b10;
      bus.write_data = 32'd0;
      refUpgWrite(i, d);
      @(posedge clock); #1;
      checkVal("upg_busy", 32'(bus.busy), 32'd1);
      checkVal("upg_novalid", 32'(bus.read_valid), 32'd0);
    end
    bus.upg_wen   = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b1;
    @(posedge clock); #1;
    bus.mem_read = 1'b0;
    checkVal("upg_read_ignored", 32'(bus.read_valid), 32'd0);
    d = $urandom;
    bus.upg_wen  = 1'b1;
    bus.upg_adr  = AW'(15);
    bus.upg_dat  = d;
    bus.upg_done = 1'b1;
    refUpgWrite(15, d);
    @(posedge clock); #1;
    idleInputs();
    checkVal("upg_busy_fall", 32'(bus.busy), 32'd0);
    cpuOp(1'b1, 1'b0, 32'hC, 2'b10, 1'b0, 32'd0, "upg_rd3");
    checkVal("upg_deadbeef", bus.read_data, 32'hDEAD_BEEF);
    cpuOp(1'b1, 1'b0, 32'h3C, 2'b10, 1'b0, 32'd0, "upg_rd15");

    // Word store / back-to-back loads.
    cpuOp(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'hA000_0000, "st0");
    cpuOp(1'b0, 1'b1, 32'h4, 2'b10, 1'b0, 32'h0000_00F5, "st4");
    cpuOp(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, "ld0");
    checkVal("tp_ld0", bus.read_data, 32'hA000_0000);
    cpuOp(1'b1, 1'b0, 32'h4, 2'b10, 1'b0, 32'd0, "ld4");
    checkVal("tp_ld4", bus.read_data, 32'h0000_00F5);

    // Byte store and extension.
    cpuOp(1'b0, 1'b1, 32'h8, 2'b10, 1'b0, 32'h1122_3344, "st8");
    cpuOp(1'b0, 1'b1, 32'hA, 2'b00, 1'b0, 32'h0000_00F5, "stbA");
    cpuOp(1'b1, 1'b0, 32'h8, 2'b10, 1'b0, 32'd0, "ld8");
    checkVal("tp_byte_merge", bus.read_data, 32'h11F5_3344);
    cpuOp(1'b1, 1'b0, 32'hA, 2'b00, 1'b0, 32'd0, "lbA");
    checkVal("tp_lb_signed", bus.read_data, 32'hFFFF_FFF5);
    cpuOp(1'b1, 1'b0, 32'hA, 2'b00, 1'b1, 32'd0, "lbuA");
    checkVal("tp_lb_unsigned", bus.read_data, 32'h0000_00F5);
    cpuOp(1'b1, 1'b0, 32'h8, 2'b01, 1'b0, 32'd0, "lh8");
    checkVal("tp_lh_signed", bus.read_data, 32'h0000_3344);

    // Read+write conflict: store wins, no valid strobe.
    cpuOp(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h55, "conflict");
    cpuOp(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, "ld10");
    checkVal("tp_conflict", bus.read_data, 32'h55);

    // Misaligned word store at 0x6.
    cpuOp(1'b0, 1'b1, 32'h6, 2'b10, 1'b0, 32'hCAFE_0001, "mis_st");
    cpuOp(1'b1, 1'b0, 32'h4, 2'b10, 1'b0, 32'd0, "mis_ld4");
    checkVal("tp_mis_word4", bus.read_data, TRAP ? 32'h0000_00F5 : 32'hCAFE_0001);

    // Out of range: store dropped (would alias word 0), load returns 0 with valid.
    cpuOp(1'b0, 1'b1, 32'h0001_0000, 2'b10, 1'b0, 32'h1234_5678, "oor_st");
    cpuOp(1'b1, 1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'd0, "oor_ld");
    cpuOp(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, "oor_alias");
    checkVal("tp_oor_alias", bus.read_data, 32'hA000_0000);

    // Reset in the middle of UPG; the write in the reset cycle is dropped.
    bus.upg_start = 1'b1;
    @(posedge clock); #1;
    bus.upg_start = 1'b0;
    checkVal("rst_upg_busy", 32'(bus.busy), 32'd1);
    bus.upg_wen = 1'b1;
    bus.upg_adr = AW'(0);
    bus.upg_dat = 32'h9999_9999;
    reset       = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    idleInputs();
    expData = 32'd0;
    checkVal("rst_upg_busy0", 32'(bus.busy), 32'd0);
    checkVal("rst_upg_valid0", 32'(bus.read_valid), 32'd0);
    checkVal("rst_upg_data0", bus.read_data, 32'd0);
    cpuOp(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, "rst_keep");
    checkVal("tp_rst_keep", bus.read_data, 32'hA000_0000);

    // Random traffic over the first 64 bytes with occasional out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a | 32'h0040_0000;
      sz = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0) ? rd : 1'($urandom_range(0, 1));
      cpuOp(rd, wr, a, sz, 1'($urandom_range(0, 1)), $urandom, "rnd");
    end

    cpuOp(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, "idle_hold");

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
